// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - Hangman letter codes, word-picker FSM states, word ROM contents and LFSR taps.
package hangman_pkg;

  localparam logic [4:0] LETTER_A = 5'd0,  LETTER_B = 5'd1,  LETTER_C = 5'd2,  LETTER_D = 5'd3;
  localparam logic [4:0] LETTER_E = 5'd4,  LETTER_F = 5'd5,  LETTER_G = 5'd6,  LETTER_H = 5'd7;
  localparam logic [4:0] LETTER_I = 5'd8,  LETTER_J = 5'd9,  LETTER_K = 5'd10, LETTER_L = 5'd11;
  localparam logic [4:0] LETTER_M = 5'd12, LETTER_N = 5'd13, LETTER_O = 5'd14, LETTER_P = 5'd15;
  localparam logic [4:0] LETTER_Q = 5'd16, LETTER_R = 5'd17, LETTER_S = 5'd18, LETTER_T = 5'd19;
  localparam logic [4:0] LETTER_U = 5'd20, LETTER_V = 5'd21, LETTER_W = 5'd22, LETTER_X = 5'd23;
  localparam logic [4:0] LETTER_Y = 5'd24, LETTER_Z = 5'd25;
  localparam logic [4:0] LETTER_BLANK = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_FETCH,
    ST_LOAD,
    ST_READY
  } state_e;

  // Fibonacci taps at bits 15,13,12,10 for x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [3:0]  NO_REPEAT_MAX = 4'd13;
  localparam int          ROM_DEPTH     = 16;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  localparam logic [24:0] WORD_ROM [ROM_DEPTH] = '{
    {LETTER_S, LETTER_T, LETTER_A, LETTER_Y, LETTER_BLANK},
    {LETTER_H, LETTER_A, LETTER_N, LETTER_G, LETTER_BLANK},
    {LETTER_L, LETTER_O, LETTER_G, LETTER_I, LETTER_C},
    {LETTER_C, LETTER_L, LETTER_O, LETTER_C, LETTER_K},
    {LETTER_R, LETTER_O, LETTER_P, LETTER_E, LETTER_BLANK},
    {LETTER_G, LETTER_U, LETTER_E, LETTER_S, LETTER_S},
    {LETTER_T, LETTER_R, LETTER_E, LETTER_E, LETTER_BLANK},
    {LETTER_A, LETTER_P, LETTER_P, LETTER_L, LETTER_E},
    {LETTER_W, LETTER_O, LETTER_R, LETTER_D, LETTER_BLANK},
    {LETTER_P, LETTER_L, LETTER_A, LETTER_N, LETTER_T},
    {LETTER_F, LETTER_L, LETTER_A, LETTER_S, LETTER_H},
    {LETTER_G, LETTER_A, LETTER_M, LETTER_E, LETTER_BLANK},
    {LETTER_Q, LETTER_U, LETTER_I, LETTER_Z, LETTER_BLANK},
    {LETTER_M, LETTER_A, LETTER_G, LETTER_I, LETTER_C},
    {LETTER_J, LETTER_U, LETTER_M, LETTER_P, LETTER_BLANK},
    {LETTER_B, LETTER_R, LETTER_A, LETTER_V, LETTER_E}
  };

endpackage

// File: rtl/word_rom.sv
// rtl/word_rom.sv - synchronous-read word ROM with registered 25-bit output.
module word_rom
  import hangman_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [24:0]       data_o
);

  logic [24:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= {5{LETTER_BLANK}};
    end else begin
      data_q <= WORD_ROM[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/word_picker.sv
// rtl/word_picker.sv - Hangman secret-word selector: free-running LFSR indexes the word ROM, word held per round.
// Optional WORD_PICKER_NO_REPEAT_EN: redraw (up to 13 retries) when the index matches the previous word.
module word_picker
  import hangman_pkg::*;
#(
  parameter int          WORDS     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     new_game,
  output logic [4:0]               letter1,
  output logic [4:0]               letter2,
  output logic [4:0]               letter3,
  output logic [4:0]               letter4,
  output logic [4:0]               letter5,
  output logic [2:0]               word_len,
  output logic [$clog2(WORDS)-1:0] word_idx,
  output logic                     word_valid
);

  localparam int IDX_W = $clog2(WORDS);

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic              new_game_q;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [24:0]       word_q, word_d;
  logic [2:0]        len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [24:0]       rom_data;
  logic              req;
  logic [IDX_W-1:0]  cand;
`ifdef WORD_PICKER_NO_REPEAT_EN
  logic              had_word_q, had_word_d;
  logic [3:0]        retry_q, retry_d;
`endif

  assign req  = new_game & ~new_game_q;
  assign cand = lfsr_q[IDX_W-1:0];

  word_rom #(.ADDR_W(IDX_W)) u_rom (
    .clk_i   (clk),
    .reset_i (reset),
    .addr_i  (addr_q),
    .data_o  (rom_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    len_d   = len_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifdef WORD_PICKER_NO_REPEAT_EN
    had_word_d = had_word_q;
    retry_d    = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (req) begin
          state_d = ST_DRAW;
`ifdef WORD_PICKER_NO_REPEAT_EN
          had_word_d = 1'b0;
`endif
        end
      end
      ST_DRAW: begin
        addr_d  = cand;
        state_d = ST_FETCH;
`ifdef WORD_PICKER_NO_REPEAT_EN
        // Stay in DRAW while the LFSR keeps offering the previous word's index.
        if (had_word_q && (cand == idx_q) && (retry_q < NO_REPEAT_MAX)) begin
          state_d = ST_DRAW;
          retry_d = retry_q + 4'd1;
        end else begin
          retry_d = 4'd0;
        end
`endif
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        word_d  = rom_data;
        len_d   = (rom_data[4:0] == LETTER_BLANK) ? 3'd4 : 3'd5;
        idx_d   = addr_q;
        valid_d = 1'b1;
        state_d = ST_READY;
      end
      ST_READY: begin
        if (req) begin
          valid_d = 1'b0;
          state_d = ST_DRAW;
`ifdef WORD_PICKER_NO_REPEAT_EN
          had_word_d = valid_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LFSR_SEED;
      new_game_q <= 1'b0;
      addr_q     <= '0;
      word_q     <= {5{LETTER_BLANK}};
      len_q      <= 3'd0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
`ifdef WORD_PICKER_NO_REPEAT_EN
      had_word_q <= 1'b0;
      retry_q    <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_step(lfsr_q);
      new_game_q <= new_game;
      addr_q     <= addr_d;
      word_q     <= word_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
`ifdef WORD_PICKER_NO_REPEAT_EN
      had_word_q <= had_word_d;
      retry_q    <= retry_d;
`endif
    end
  end

  assign letter1    = word_q[24:20];
  assign letter2    = word_q[19:15];
  assign letter3    = word_q[14:10];
  assign letter4    = word_q[9:5];
  assign letter5    = word_q[4:0];
  assign word_len   = len_q;
  assign word_idx   = idx_q;
  assign word_valid = valid_q;

endmodule
